// File: rtl/bsg_cache_dma_mem_tester.sv
// DRAM bring-up traffic generator/checker on the bsg_cache DMA interface.
// Writes num_bursts_p patterned bursts, reads them back and reports mismatches.
module bsg_cache_dma_mem_tester #(
    parameter int              addr_width_p = 28,
    parameter int              data_width_p = 64,
    parameter int              burst_len_p  = 8,
    parameter int              num_bursts_p = 16,
    parameter longint unsigned base_addr_p  = 'h100,
    parameter longint unsigned stride_p     = burst_len_p * data_width_p / 8,
    parameter int              timeout_p    = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic [1:0]                     mode_i,
    output logic [addr_width_p:0]          dma_pkt_o,
    output logic                           dma_pkt_v_o,
    input  logic                           dma_pkt_yumi_i,
    output logic [data_width_p-1:0]        dma_data_o,
    output logic                           dma_data_v_o,
    input  logic                           dma_data_yumi_i,
    input  logic [data_width_p-1:0]        dma_data_i,
    input  logic                           dma_data_v_i,
    output logic                           dma_data_ready_and_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           timeout_o,
    output logic [15:0]                    error_count_o,
    output logic [addr_width_p-1:0]        fail_addr_o,
    output logic [$clog2(burst_len_p)-1:0] fail_beat_o
);

    localparam int beat_w  = $clog2(burst_len_p);
    localparam int burst_w = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;
    localparam int cnt_w   = $clog2(timeout_p + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_PKT  = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_PKT  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [beat_w-1:0]  last_beat  = beat_w'(burst_len_p - 1);
    localparam logic [burst_w-1:0] last_burst = burst_w'(num_bursts_p - 1);
    localparam logic [cnt_w-1:0]   to_last    = cnt_w'(timeout_p - 1);

    function automatic logic [addr_width_p-1:0] addr_of(input logic [burst_w-1:0] b);
        logic [63:0] a;
        a = 64'(base_addr_p) + 64'(b) * 64'(stride_p);
        return a[addr_width_p-1:0];
    endfunction

    function automatic logic [data_width_p-1:0] pattern(input logic [1:0] m,
                                                        input logic [burst_w-1:0] b,
                                                        input logic [beat_w-1:0] bt);
        logic [31:0]             g;
        logic [63:0]             la;
        logic [data_width_p-1:0] p0, p1, r;
        g  = 32'(b) * 32'(burst_len_p) + 32'(bt);
        la = 64'(addr_of(b)) + 64'(bt) * 64'(data_width_p / 8);
        p0 = '0;
        p0[31:0] = 32'hDEADBEEF;
        p0[data_width_p-1 -: 32] = g;
        p1 = '0;
        for (int i = 0; i < data_width_p / 32; i++) p1[i*32 +: 32] = la[31:0];
        case (m)
            2'd0:    r = p0;
            2'd1:    r = p1;
            2'd2:    r = ~p0;
            default: r = {{(data_width_p-1){1'b0}}, 1'b1} << (g % 32'(data_width_p));
        endcase
        return r;
    endfunction

    logic [2:0]              state_r;
    logic [1:0]              mode_r;
    logic [burst_w-1:0]      burst_r;
    logic [beat_w-1:0]       beat_r;
    logic [cnt_w-1:0]        tcnt_r;
    logic [addr_width_p:0]   pkt_r;
    logic [data_width_p-1:0] data_r;
    logic                    done_r, pass_r, timeout_r;
    logic [15:0]             error_count_r;
    logic [addr_width_p-1:0] fail_addr_r;
    logic [beat_w-1:0]       fail_beat_r;

    logic active, hs, mismatch;

    assign dma_pkt_v_o          = (state_r == WR_PKT) || (state_r == RD_PKT);
    assign dma_data_v_o         = (state_r == WR_DATA);
    assign dma_data_ready_and_o = (state_r == RD_DATA);

    assign active   = dma_pkt_v_o || dma_data_v_o || dma_data_ready_and_o;
    assign hs       = (dma_pkt_v_o && dma_pkt_yumi_i)
                   || (dma_data_v_o && dma_data_yumi_i)
                   || (dma_data_ready_and_o && dma_data_v_i);
    assign mismatch = (dma_data_i != pattern(mode_r, burst_r, beat_r));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= IDLE;
            mode_r        <= '0;
            burst_r       <= '0;
            beat_r        <= '0;
            tcnt_r        <= '0;
            pkt_r         <= '0;
            data_r        <= '0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            error_count_r <= '0;
            fail_addr_r   <= '0;
            fail_beat_r   <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: if (start_i) begin
                    mode_r        <= mode_i;
                    burst_r       <= '0;
                    beat_r        <= '0;
                    done_r        <= 1'b0;
                    pass_r        <= 1'b0;
                    timeout_r     <= 1'b0;
                    error_count_r <= '0;
                    fail_addr_r   <= '0;
                    fail_beat_r   <= '0;
                    pkt_r         <= {1'b1, addr_of('0)};
                    state_r       <= WR_PKT;
                end
                WR_PKT: if (dma_pkt_yumi_i) begin
                    data_r  <= pattern(mode_r, burst_r, '0);
                    state_r <= WR_DATA;
                end
                WR_DATA: if (dma_data_yumi_i) begin
                    if (beat_r == last_beat) begin
                        beat_r <= '0;
                        if (burst_r == last_burst) begin
                            burst_r <= '0;
                            pkt_r   <= {1'b0, addr_of('0)};
                            state_r <= RD_PKT;
                        end else begin
                            burst_r <= burst_r + 1'b1;
                            pkt_r   <= {1'b1, addr_of(burst_r + 1'b1)};
                            state_r <= WR_PKT;
                        end
                    end else begin
                        beat_r <= beat_r + 1'b1;
                        data_r <= pattern(mode_r, burst_r, beat_r + 1'b1);
                    end
                end
                RD_PKT: if (dma_pkt_yumi_i) state_r <= RD_DATA;
                RD_DATA: if (dma_data_v_i) begin
                    if (mismatch) begin
                        if (error_count_r != 16'hFFFF) error_count_r <= error_count_r + 16'd1;
                        if (error_count_r == '0) begin
                            fail_addr_r <= addr_of(burst_r);
                            fail_beat_r <= beat_r;
                        end
                    end
                    if (beat_r == last_beat) begin
                        beat_r <= '0;
                        if (burst_r == last_burst) begin
                            done_r  <= 1'b1;
                            pass_r  <= (error_count_r == '0) && !mismatch;
                            state_r <= DONE;
                        end else begin
                            burst_r <= burst_r + 1'b1;
                            pkt_r   <= {1'b0, addr_of(burst_r + 1'b1)};
                            state_r <= RD_PKT;
                        end
                    end else begin
                        beat_r <= beat_r + 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase

            // Stall watchdog; every state entry coincides with a handshake or start.
            if (active && !hs) begin
                if (tcnt_r == to_last) begin
                    state_r   <= DONE;
                    timeout_r <= 1'b1;
                    done_r    <= 1'b1;
                    pass_r    <= 1'b0;
                end else begin
                    tcnt_r <= tcnt_r + 1'b1;
                end
            end else begin
                tcnt_r <= '0;
            end
        end
    end

    assign dma_pkt_o     = pkt_r;
    assign dma_data_o    = data_r;
    assign done_o        = done_r;
    assign pass_o        = pass_r;
    assign timeout_o     = timeout_r;
    assign error_count_o = error_count_r;
    assign fail_addr_o   = fail_addr_r;
    assign fail_beat_o   = fail_beat_r;

endmodule

// File: tb/tb_bsg_cache_dma_mem_tester.sv
// Bench for bsg_cache_dma_mem_tester: randomized DMA memory model plus a table of test passes.
module tb_bsg_cache_dma_mem_tester;

    localparam int              AW     = 28;
    localparam int              DW     = 64;
    localparam int              BL     = 8;
    localparam int              NB     = 16;
    localparam longint unsigned BASE   = 'h100;
    localparam longint unsigned STRIDE = 64;

    typedef struct {
        int     mode;
        bit     flip;
        int     stall;
        bit     exp_pass;
        int     exp_err;
        longint exp_fa;
        int     exp_fb;
    } vec_t;

    logic clk = 0, rst = 1, start = 0, start2 = 0;
    logic [1:0] mode = 0;

    logic [AW:0]   pkt;
    logic          pkt_v, pkt_yumi = 0;
    logic [DW-1:0] dout;
    logic          dout_v, dout_yumi = 0;
    logic [DW-1:0] din = 0;
    logic          din_v = 0, din_ready;
    logic          done, pass, tmo;
    logic [15:0]   err;
    logic [AW-1:0] faddr;
    logic [2:0]    fbeat;

    logic [12:0]   pkt2;
    logic          pkt_v2, pkt_yumi2 = 0;
    logic [DW-1:0] dout2;
    logic          dout_v2, dout_yumi2 = 0;
    logic          din_ready2, done2, pass2, tmo2;
    logic [15:0]   err2;
    logic [11:0]   faddr2;
    logic [2:0]    fbeat2;
    logic [DW-1:0] din2 = 0;
    logic          din_v2 = 0;

    always #5 clk = ~clk;

    bsg_cache_dma_mem_tester u_dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode),
        .dma_pkt_o(pkt), .dma_pkt_v_o(pkt_v), .dma_pkt_yumi_i(pkt_yumi),
        .dma_data_o(dout), .dma_data_v_o(dout_v), .dma_data_yumi_i(dout_yumi),
        .dma_data_i(din), .dma_data_v_i(din_v), .dma_data_ready_and_o(din_ready),
        .done_o(done), .pass_o(pass), .timeout_o(tmo), .error_count_o(err),
        .fail_addr_o(faddr), .fail_beat_o(fbeat)
    );

    bsg_cache_dma_mem_tester #(.addr_width_p(12), .base_addr_p('hFC0), .num_bursts_p(4)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .start_i(start2), .mode_i(2'd0),
        .dma_pkt_o(pkt2), .dma_pkt_v_o(pkt_v2), .dma_pkt_yumi_i(pkt_yumi2),
        .dma_data_o(dout2), .dma_data_v_o(dout_v2), .dma_data_yumi_i(dout_yumi2),
        .dma_data_i(din2), .dma_data_v_i(din_v2), .dma_data_ready_and_o(din_ready2),
        .done_o(done2), .pass_o(pass2), .timeout_o(tmo2), .error_count_o(err2),
        .fail_addr_o(faddr2), .fail_beat_o(fbeat2)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected beat straight from the pattern definitions.
    function automatic logic [63:0] exp_pat(input int m, input int b, input int bt);
        longint unsigned a;
        logic [31:0]     g, lane;
        logic [63:0]     r;
        a    = (BASE + longint'(b) * STRIDE) % (64'd1 << AW);
        g    = 32'(b * BL + bt);
        lane = 32'((a + longint'(bt) * 8) & 64'hFFFF_FFFF);
        case (m)
            0:       r = {g, 32'hDEADBEEF};
            1:       r = {lane, lane};
            2:       r = ~{g, 32'hDEADBEEF};
            default: begin r = 0; r[g % 64] = 1'b1; end
        endcase
        return r;
    endfunction

    // Memory model state.
    bit            no_yumi = 0;
    int            stall_pct = 0;
    int            cur_mode = 0;
    int            wn = 0;
    int            wbeat = 0;
    logic [AW-1:0] waddr = 0;
    logic [DW-1:0] rdq[$];
    logic [DW-1:0] mem[longint];
    logic [AW:0]   pkt_log[$];
    logic [11:0]   q2[$];
    longint        flip_addr = -1;
    int            flip_beat = 3;

    bit            prev_rst = 1, prev_pv = 0, prev_py = 0, prev_dv = 0, prev_dy = 0;
    logic [AW:0]   prev_pkt = 0;
    logic [DW-1:0] prev_d = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !prev_rst && !tmo) begin
                if (prev_pv && !prev_py) chk("pkt_hold", {35'd0, pkt_v, pkt}, {35'd0, 1'b1, prev_pkt});
                if (prev_dv && !prev_dy) chk("data_hold", 64'(dout_v && dout == prev_d), 64'd1);
            end
            pkt_yumi = 0; dout_yumi = 0; din_v = 0;
            pkt_yumi2 = 0; dout_yumi2 = 0;
            if (!rst) begin
                if (pkt_v && !no_yumi && $urandom_range(99) >= stall_pct) begin
                    pkt_yumi = 1;
                    pkt_log.push_back(pkt);
                    if (pkt[AW]) begin
                        waddr = pkt[AW-1:0];
                        wbeat = 0;
                    end else begin
                        for (int i = 0; i < BL; i++) begin
                            logic [DW-1:0] d;
                            d = mem[longint'(pkt[AW-1:0]) + i * 8];
                            if (longint'(pkt[AW-1:0]) == flip_addr && i == flip_beat) d ^= 64'h20;
                            rdq.push_back(d);
                        end
                    end
                end
                if (dout_v && $urandom_range(99) >= stall_pct) begin
                    dout_yumi = 1;
                    mem[longint'(waddr) + wbeat * 8] = dout;
                    chk("wr_data", dout, exp_pat(cur_mode, wn / BL, wn % BL));
                    wn++;
                    wbeat++;
                end
                if (rdq.size() > 0) begin
                    if ($urandom_range(99) >= stall_pct) begin
                        din_v = 1;
                        din = rdq[0];
                        if (din_ready) void'(rdq.pop_front());
                    end
                end else if (!din_ready) begin
                    din_v = 1'($urandom_range(1));
                    din = {$urandom, $urandom};
                end
                pkt_yumi2 = pkt_v2;
                if (pkt_v2 && pkt2[12]) q2.push_back(pkt2[11:0]);
                dout_yumi2 = dout_v2;
            end
            prev_rst = rst; prev_pv = pkt_v; prev_py = pkt_yumi;
            prev_dv = dout_v; prev_dy = dout_yumi; prev_pkt = pkt; prev_d = dout;
        end
    end

    task automatic run_pass(input int m, input bit also2);
        int cyc;
        cur_mode = m; wn = 0;
        rdq.delete(); pkt_log.delete();
        mode = 2'(m);
        start = 1;
        if (also2) start2 = 1;
        @(negedge clk);
        start = 0; start2 = 0;
        mode = ~2'(m);
        chk("first_pkt_v", 64'(pkt_v), 64'd1);
        chk("first_pkt", 64'(pkt), {35'd0, 1'b1, 28'h100});
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done", 64'(done), 64'd1);
        chk("wr_beats", 64'(wn), 64'(NB * BL));
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{0, 1'b0, 0,  1'b1, 0, 0,     0};
        vecs[1] = '{0, 1'b1, 0,  1'b0, 1, 'h180, 3};
        vecs[2] = '{1, 1'b0, 30, 1'b1, 0, 0,     0};
        vecs[3] = '{2, 1'b0, 30, 1'b1, 0, 0,     0};
        vecs[4] = '{3, 1'b0, 0,  1'b1, 0, 0,     0};
        vecs[5] = '{1, 1'b1, 30, 1'b0, 1, 'h180, 3};

        @(negedge clk);
        chk("rst_pkt_v", 64'(pkt_v), 0);
        chk("rst_data_v", 64'(dout_v), 0);
        chk("rst_ready", 64'(din_ready), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_pass", 64'(pass), 0);
        chk("rst_timeout", 64'(tmo), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_fail_addr", 64'(faddr), 0);
        chk("rst_fail_beat", 64'(fbeat), 0);
        chk("rst_pkt", 64'(pkt), 0);
        chk("rst_data", dout, 0);

        start = 1;
        @(negedge clk);
        chk("rst_wins", 64'(pkt_v), 0);
        start = 0; rst = 0;
        @(negedge clk);
        chk("idle_hold", 64'(pkt_v), 0);

        for (int i = 0; i < 6; i++) begin
            flip_addr = vecs[i].flip ? 'h180 : -1;
            stall_pct = vecs[i].stall;
            run_pass(vecs[i].mode, i == 0);
            chk($sformatf("v%0d_pass", i), 64'(pass), 64'(vecs[i].exp_pass));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_timeout", i), 64'(tmo), 0);
            chk($sformatf("v%0d_fail_addr", i), 64'(faddr), 64'(vecs[i].exp_fa));
            chk($sformatf("v%0d_fail_beat", i), 64'(fbeat), 64'(vecs[i].exp_fb));
            if (i == 0) begin
                chk("beat0", mem['h100], 64'h00000000_DEADBEEF);
                chk("beat9", mem['h100 + 9 * 8], 64'h00000009_DEADBEEF);
                chk("first_rd_pkt", 64'(pkt_log[NB]), {35'd0, 1'b0, 28'h100});
            end
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_done_hold", i), 64'(done), 1);
        end

        chk("wrap_cnt", 64'(q2.size()), 4);
        if (q2.size() == 4) begin
            chk("wrap_a0", 64'(q2[0]), 'hFC0);
            chk("wrap_a1", 64'(q2[1]), 'h000);
            chk("wrap_a2", 64'(q2[2]), 'h040);
            chk("wrap_a3", 64'(q2[3]), 'h080);
        end

        // Packet never accepted: watchdog fires after exactly 1024 valid cycles.
        no_yumi = 1; stall_pct = 0; flip_addr = -1;
        cur_mode = 0; wn = 0; rdq.delete();
        start = 1; mode = 0;
        @(negedge clk);
        start = 0;
        chk("to_first_v", 64'(pkt_v), 1);
        repeat (1023) @(negedge clk);
        chk("to_v_last", 64'(pkt_v), 1);
        chk("to_not_yet", 64'(tmo), 0);
        @(negedge clk);
        chk("to_v_drop", 64'(pkt_v), 0);
        chk("to_timeout", 64'(tmo), 1);
        chk("to_done", 64'(done), 1);
        chk("to_pass", 64'(pass), 0);
        no_yumi = 0;

        // Reset in the middle of the write phase, then rerun.
        cur_mode = 0; wn = 0; rdq.delete();
        start = 1; mode = 0;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!dout_v && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("saw_wr_data", 64'(dout_v), 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_pkt_v", 64'(pkt_v), 0);
        chk("mid_rst_data_v", 64'(dout_v), 0);
        chk("mid_rst_ready", 64'(din_ready), 0);
        chk("mid_rst_done", 64'(done), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        stall_pct = 20;
        run_pass(1, 1'b0);
        chk("rerun_pass", 64'(pass), 1);
        chk("rerun_err", 64'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsg_cache_dma_mem_tester.md
Name: bsg_cache_dma_mem_tester

Overview:
- Synthesizable traffic generator/checker on the bsg_cache DMA interface, the interface mig_ddr3_ram exposes to the core side.
- Writes a parametrised number of multi-beat bursts with a selectable data pattern, then reads every burst back and compares it.
- Reports pass/fail, an error count, the first failing location and timeouts.
- Used for on-board DRAM bring-up in place of the core and as a reusable bench driver.

Parameters:
- addr_width_p, 28, DMA address width (caddr width).
- data_width_p, 64, DMA beat width. Must be a multiple of 32 and at least 64.
- burst_len_p, 8, beats per DMA packet.
- num_bursts_p, 16, bursts per test pass. Must be at least 1.
- base_addr_p, 'h100, byte address of burst 0.
- stride_p, burst_len_p*data_width_p/8, byte distance between burst start addresses.
- timeout_p, 1024, maximum cycles waiting on any single handshake.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begins a test pass. Sampled in IDLE and DONE only.
- mode_i  in  2  pattern select, latched at start.
- dma_pkt_o  out  1+addr_width_p  {write_not_read, addr}.
- dma_pkt_v_o  out  1  packet valid.
- dma_pkt_yumi_i  in  1  packet consumed.
- dma_data_o  out  data_width_p  write beat.
- dma_data_v_o  out  1  write beat valid.
- dma_data_yumi_i  in  1  write beat consumed.
- dma_data_i  in  data_width_p  read beat.
- dma_data_v_i  in  1  read beat valid.
- dma_data_ready_and_o  out  1  ready for a read beat.
- done_o  out  1  test pass finished.
- pass_o  out  1  finished with zero errors and no timeout.
- timeout_o  out  1  a handshake timed out.
- error_count_o  out  16  mismatching beats, saturating at 'hFFFF.
- fail_addr_o  out  addr_width_p  burst address of the first mismatch.
- fail_beat_o  out  $clog2(burst_len_p)  beat index of the first mismatch.

Behaviour:
- Reset (async, immediate): FSM goes to IDLE. All outputs are 0, including every valid/ready, done_o, pass_o, timeout_o, error_count_o, fail_addr_o, fail_beat_o, dma_pkt_o and dma_data_o.
- States: IDLE, WR_PKT, WR_DATA, RD_PKT, RD_DATA, DONE.
- IDLE/DONE + start_i:
  - clear error_count_o, fail_addr_o, fail_beat_o, timeout_o, done_o and pass_o;
  - latch mode_i;
  - set burst=0, beat=0;
  - go to WR_PKT.
- WR_PKT: dma_pkt_v_o=1, pkt={1, addr(burst)}. On yumi, go to WR_DATA.
- WR_DATA: dma_data_v_o=1, dma_data_o=pattern(burst, beat). On yumi, beat++.
  - After the last beat: burst++ and go to WR_PKT, or, after the last burst, set burst=0 and go to RD_PKT.
- RD_PKT: pkt={0, addr(burst)}. On yumi, go to RD_DATA.
- RD_DATA: dma_data_ready_and_o=1. Each beat with dma_data_v_i=1 is compared to pattern(burst, beat).
  - On mismatch, error_count_o increments (saturating).
  - On the first mismatch of the pass, capture fail_addr_o and fail_beat_o.
  - After the last beat: next burst goes to RD_PKT, or, after the last burst, go to DONE.
- dma_data_v_i is ignored while dma_data_ready_and_o=0.
- DONE: done_o=1 and pass_o=(error_count_o==0 && !timeout_o). Both hold until start_i or reset.
- addr(b) = (base_addr_p + b*stride_p) mod 2^addr_width_p. Wrap-around is silent.
- Global beat index g = b*burst_len_p + beat, 32 bits.
- Patterns:
  - mode 0: top 32 bits = g, bottom 32 bits = 'hDEADBEEF, middle bits 0.
  - mode 1: every 32-bit lane = low 32 bits of (addr(b) + beat*data_width_p/8).
  - mode 2: bitwise inverse of mode 0.
  - mode 3: walking one, bit (g mod data_width_p) set.
- Handshakes:
  - dma_pkt_o and dma_data_o are registered and stay stable while the matching valid is high.
  - A valid never drops without its yumi.
  - A yumi with valid low is ignored.
  - The first packet is presented the cycle after start_i.
  - Zero-bubble beats: at most one beat per cycle in each direction.
- Timeout:
  - A counter resets on every state entry and on every handshake, and increments while stalled in WR_PKT, WR_DATA, RD_PKT or RD_DATA.
  - Reaching timeout_p sets timeout_o=1 and goes to DONE, dropping all valid/ready outputs that cycle.
- Simultaneous start_i with reset_i: reset wins.

Test Plan:
- Defaults, mode 0, ideal DMA memory model:
  - the first write packet is {1,'h100} and the first read packet is {0,'h100};
  - read beat 0 = 'h00000000_DEADBEEF, beat 9 = 'h00000009_DEADBEEF;
  - the pass ends with done_o=1, pass_o=1, error_count_o=0.
- Model flips bit 5 of read beat 3 of burst 2 -> error_count_o=1, fail_addr_o='h180, fail_beat_o=3, pass_o=0.
- Model never asserts dma_pkt_yumi_i -> exactly 1024 cycles after the first dma_pkt_v_o: timeout_o=1, done_o=1, pass_o=0, dma_pkt_v_o=0.
- Random yumi and valid gaps (30% stall) in mode 1 -> pass_o=1; dma_pkt_o and dma_data_o are stable whenever their valid is high and yumi is low.
- addr_width_p=12, base_addr_p='hFC0, num_bursts_p=4 -> write packet addresses 'hFC0, 'h000, 'h040, 'h080.
- reset_i pulsed mid-WR_DATA -> all valid outputs 0 in the same cycle; a subsequent start_i reruns and ends with pass_o=1.
